// File: rtl/ctrl_uart_rx.sv
// 8N1 UART receiver with 16x oversampling feeding a first-word-fall-through RX FIFO.
// Framing and overrun errors are sticky until err_clr; reception never stalls on them.
module ctrl_uart_rx #(
    parameter int SAMPLE_CNT = 27,
    parameter int FIFO_AW    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               uart_rxd,
    input  logic               rd_en,
    output logic [7:0]         rd_dat,
    output logic               rd_valid,
    output logic [FIFO_AW:0]   fifo_cnt,
    output logic               rx_busy,
    output logic               frm_err,
    output logic               ovr_err,
    input  logic               err_clr
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [7:0] RELOAD = 8'(SAMPLE_CNT - 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t state, state_nxt;

    logic       sync1, sync2, rxd_d;
    logic       fall, start_det, tick, sample;
    logic [7:0] presc;
    logic [3:0] os_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       push_req;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic               full, empty, do_push, do_pop, ovr_set, frm_set;

    assign fall      = rxd_d & ~sync2;
    assign start_det = (state == IDLE) && fall;
    assign tick      = (state != IDLE) && (presc == 8'd0);
    assign sample    = tick && (os_cnt == 4'd7);
    assign rx_busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            sync2 <= sync1;
            rxd_d <= sync2;
        end
    end

    // Prescaler is restarted on the start edge so the sample point lands mid-bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= RELOAD;
            os_cnt <= 4'd0;
        end else begin
            if (start_det)
                presc <= RELOAD;
            else if (state != IDLE)
                presc <= (presc == 8'd0) ? RELOAD : presc - 8'd1;
            if (start_det)
                os_cnt <= 4'd0;
            else if (tick)
                os_cnt <= os_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (fall) state_nxt = START;
            START: if (sample) state_nxt = sync2 ? IDLE : DATA;
            DATA:  if (sample && bit_idx == 3'd7) state_nxt = STOP;
            STOP:  if (sample) state_nxt = sync2 ? IDLE : BRK;
            BRK:   if (sync2) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx  <= 3'd0;
            shreg    <= 8'd0;
            push_req <= 1'b0;
        end else begin
            push_req <= (state == STOP) && sample && sync2;
            if (state == START && sample)
                bit_idx <= 3'd0;
            else if (state == DATA && sample) begin
                shreg[bit_idx] <= sync2;
                bit_idx        <= bit_idx + 3'd1;
            end
        end
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO is not an overrun
    assign empty   = (fifo_cnt == '0);
    assign full    = (fifo_cnt == FULL_CNT);
    assign do_pop  = rd_en && !empty;
    assign do_push = push_req && (!full || do_pop);
    assign ovr_set = push_req && full && !do_pop;
    assign frm_set = (state == STOP) && sample && !sync2;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + PTR_ONE;
            if (do_pop)
                rptr <= rptr + PTR_ONE;
            if (do_push && !do_pop)
                fifo_cnt <= fifo_cnt + CNT_ONE;
            else if (do_pop && !do_push)
                fifo_cnt <= fifo_cnt - CNT_ONE;
        end
    end

    assign rd_valid = !empty;
    assign rd_dat   = empty ? 8'h00 : mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            if (frm_set)
                frm_err <= 1'b1;
            else if (err_clr)
                frm_err <= 1'b0;
            if (ovr_set)
                ovr_err <= 1'b1;
            else if (err_clr)
                ovr_err <= 1'b0;
        end
    end

endmodule

// File: doc/ctrl_uart_rx.md
Name: ctrl_uart_rx

Overview:
- UART receive front-end with an RX FIFO, feeding received bytes to the control register block.
- Replaces the single-byte, non-handshaked receive path. Converts the asynchronous uart_rxd line into 8N1 bytes using 16x oversampling, then buffers them in a first-word-fall-through FIFO.
- The register block pops bytes on qmem reads and reports status/error flags to the CPU.

Parameters:
- SAMPLE_CNT, 27: clocks per oversample tick (50 MHz / 115200 / 16). Legal range 2..255.
- FIFO_AW, 4: FIFO address width. Depth = 2**FIFO_AW entries.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- uart_rxd  in  1  asynchronous serial input, idle high
- rd_en  in  1  pop head byte (from register read strobe)
- rd_dat  out  8  head byte of FIFO (first-word-fall-through)
- rd_valid  out  1  FIFO not empty
- fifo_cnt  out  FIFO_AW+1  number of bytes held
- rx_busy  out  1  receiver not in IDLE
- frm_err  out  1  sticky framing error
- ovr_err  out  1  sticky overrun error
- err_clr  in  1  clear both sticky errors

Behaviour:
- Reset (rst_n low, async):
  - Synchronizer flops = 1; FSM = IDLE; prescaler = SAMPLE_CNT-1; oversample counter = 0.
  - FIFO empty: fifo_cnt=0, rd_valid=0. rd_dat = 0 (masked while empty). rx_busy=0, frm_err=0, ovr_err=0.
  - Reset mid-frame aborts the frame and discards FIFO contents.
- Input sync: two-flop synchronizer plus one delay flop (rxd_d). Falling edge = rxd_d=1 and synced=0.
- Prescaler: loads SAMPLE_CNT-1 on start detection. Outside IDLE it counts down and emits tick when 0, reloading SAMPLE_CNT-1. Held in IDLE.
- Oversample counter (4 bit): cleared on start detection, increments on each tick, wraps 15->0. The sample point is the tick where the counter == 7, i.e. mid-bit.
- FSM states:
  - IDLE: on falling edge -> START.
  - START: at sample point, line 0 -> DATA with bit index 0. Line 1 -> IDLE (glitch rejected, no error).
  - DATA: at each sample point, shift line into bit[index], LSB first. After the 8th bit -> STOP.
  - STOP: at sample point:
    - line 1 -> push byte, go to IDLE.
    - line 0 -> set frm_err, discard byte, go to BREAK.
  - BREAK: wait for synced line = 1, then -> IDLE. No new start is detected while in BREAK.
- Sample timing: first data bit sampled 16*SAMPLE_CNT clocks after the start sample point. Each following bit is a further 16*SAMPLE_CNT clocks on.
- rx_busy = (state != IDLE).
- FIFO:
  - Push occurs in the cycle after the stop sample. rd_valid goes high the cycle after the push.
  - rd_dat is the head entry combinationally, valid whenever rd_valid=1.
  - Pop on rd_en while rd_valid; rd_en while empty is ignored.
  - Push while full (fifo_cnt = 2**FIFO_AW) with no pop: byte dropped, ovr_err set.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overrun.
  - Push and pop in the same cycle when count=1: both occur, new byte becomes head.
  - Pointers are FIFO_AW bits and wrap naturally. fifo_cnt is FIFO_AW+1 bits.
- Errors: err_clr clears frm_err and ovr_err. If a set and err_clr coincide, set wins. Errors never block reception.

Test Plan (SAMPLE_CNT=4, FIFO_AW=2, bit period 64 clk):
- Single byte: drive 0xA5 8N1 at 64 clk/bit -> single push; rd_valid=1, rd_dat=0xA5, fifo_cnt=1; rd_en one cycle -> rd_valid=0, fifo_cnt=0.
- Glitch: low pulse of 20 clk on idle line -> returns to IDLE, no push, frm_err=0, rx_busy deasserted within 40 clk.
- Framing/break: send 0x3C with stop bit 0, then hold line low for 200 clk -> frm_err=1, fifo_cnt=0, state stays BREAK. Line high then byte 0x11 -> 0x11 received. err_clr -> frm_err=0.
- Overrun and wrap: send 0x01..0x05 without popping -> fifo_cnt=4, ovr_err=1, head 0x01. Pop 4 bytes in order 0x01,0x02,0x03,0x04. Refill 0x06..0x09 across pointer wrap and read back in order.
- Simultaneous push/pop at full: with FIFO full, assert rd_en in the push cycle -> fifo_cnt stays 4, ovr_err stays 0, head advances to the second entry.
- Async reset mid-frame: assert rst_n low during DATA bit 3 with 2 bytes queued -> immediately fifo_cnt=0, rd_valid=0, rx_busy=0, errors 0. After release, the next clean byte 0x7E is received correctly.
